// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash responder: oversampled SPI front end, 25-series command
// subset (WREN/WRDI/RDSR/RDID/READ/PP) and a byte-wide external memory port.
module spi_flash_responder #(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int unsigned BUSY_CYCLES = 1000
) (
  input  logic              clk_in1,
  input  logic              reset_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              wip
);

  localparam int unsigned BW = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_OUT, ID_OUT, SR_OUT, PROG_IN, IGNORE
  } state_t;

  state_t            state;
  logic [1:0]        sck_sync, cs_sync, mosi_sync;
  logic              sck_d, cs_d;
  logic              sck_rise, sck_fall, cs_fall, cs_rise, mosi_s, cs_n_s;
  logic [4:0]        bit_cnt;
  logic [2:0]        out_bit;
  logic [6:0]        shift_in;
  logic [ADDR_W-2:0] addr_sr;
  logic [6:0]        shift_out;
  logic [7:0]        rd_buf;
  logic [1:0]        rd_lat;
  logic [1:0]        id_idx;
  logic              is_read, wel, prog_any;
  logic [BW-1:0]     busy_cnt;
  logic [7:0]        rx_byte, tx_byte;
  logic [ADDR_W-1:0] addr_full;
  logic              out_state;

  assign sck_rise  = sck_sync[1] & ~sck_d;
  assign sck_fall  = ~sck_sync[1] & sck_d;
  assign cs_n_s    = cs_sync[1];
  assign cs_fall   = cs_d & ~cs_n_s;
  assign cs_rise   = ~cs_d & cs_n_s;
  assign mosi_s    = mosi_sync[1];
  assign out_state = (state == RD_OUT) || (state == ID_OUT) || (state == SR_OUT);

  always_comb begin
    rx_byte   = {shift_in, mosi_s};
    addr_full = {addr_sr, mosi_s};
    tx_byte   = 8'hFF;
    case (state)
      RD_OUT: tx_byte = rd_buf;
      SR_OUT: tx_byte = {6'b0, wel, wip};
      ID_OUT: begin
        case (id_idx)
          2'd0: tx_byte = JEDEC_ID[23:16];
          2'd1: tx_byte = JEDEC_ID[15:8];
          2'd2: tx_byte = JEDEC_ID[7:0];
          2'd3: tx_byte = 8'hFF;
        endcase
      end
      default: tx_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sck_sync    <= '0;
      cs_sync     <= '1;
      mosi_sync   <= '0;
      sck_d       <= 1'b0;
      cs_d        <= 1'b1;
      bit_cnt     <= '0;
      out_bit     <= '0;
      shift_in    <= '0;
      addr_sr     <= '0;
      shift_out   <= '0;
      rd_buf      <= '0;
      rd_lat      <= '0;
      id_idx      <= '0;
      is_read     <= 1'b0;
      wel         <= 1'b0;
      prog_any    <= 1'b0;
      busy_cnt    <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      wip         <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_d     <= sck_sync[1];
      cs_d      <= cs_n_s;
      mem_we    <= 1'b0;

      // Registered memory: data for an address change lands two edges later.
      rd_lat <= {rd_lat[0], 1'b0};
      if (rd_lat[1]) rd_buf <= mem_rdata;

      // Page-local increment runs the cycle after the strobe so the write sees the old address.
      if (mem_we) mem_addr[7:0] <= mem_addr[7:0] + 8'd1;

      if (busy_cnt != '0) busy_cnt <= busy_cnt - BW'(1);
      if (busy_cnt <= BW'(1)) wip <= 1'b0;

      if (cs_n_s) begin
        state       <= IDLE;
        spi_miso_oe <= 1'b0;
        bit_cnt     <= '0;
        out_bit     <= '0;
        prog_any    <= 1'b0;
        if (cs_rise && prog_any) begin
          wel      <= 1'b0;
          wip      <= 1'b1;
          busy_cnt <= BW'(BUSY_CYCLES);
        end
      end else begin
        if (sck_fall && out_state) begin
          spi_miso_oe <= 1'b1;
          out_bit     <= out_bit + 3'd1;
          if (out_bit == 3'd0) begin
            spi_miso  <= tx_byte[7];
            shift_out <= tx_byte[6:0];
            if (state == ID_OUT && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
          end else begin
            spi_miso  <= shift_out[6];
            shift_out <= {shift_out[5:0], 1'b0};
          end
        end

        case (state)
          IDLE: if (cs_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (sck_rise) begin
            shift_in <= {shift_in[5:0], mosi_s};
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              out_bit <= '0;
              id_idx  <= '0;
              is_read <= (rx_byte == 8'h03);
              state   <= IGNORE;
              if (rx_byte == 8'h05) begin
                state <= SR_OUT;
              end else if (!wip) begin
                case (rx_byte)
                  8'h06:        wel   <= 1'b1;
                  8'h04:        wel   <= 1'b0;
                  8'h9F:        state <= ID_OUT;
                  8'h03, 8'h02: state <= ADDR;
                  default:      ;
                endcase
              end
            end
          end
          ADDR: if (sck_rise) begin
            addr_sr <= addr_full[ADDR_W-2:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt  <= '0;
              mem_addr <= addr_full;
              if (is_read) begin
                state  <= RD_OUT;
                rd_lat <= {rd_lat[0], 1'b1};
              end else if (wel) begin
                state <= PROG_IN;
              end else begin
                state <= IGNORE;
              end
            end
          end
          RD_OUT: if (sck_rise) begin
            bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
            if (bit_cnt[2:0] == 3'd7) begin
              mem_addr <= mem_addr + ADDR_W'(1);
              rd_lat   <= {rd_lat[0], 1'b1};
            end
          end
          PROG_IN: if (sck_rise) begin
            shift_in <= {shift_in[5:0], mosi_s};
            bit_cnt  <= {2'b00, bit_cnt[2:0] + 3'd1};
            if (bit_cnt[2:0] == 3'd7) begin
              mem_we    <= 1'b1;
              mem_wdata <= rx_byte;
              prog_any  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
